// File: rtl/bsg_manycore_cache_req_merge.sv
// rtl/bsg_manycore_cache_req_merge.sv - two-port request merger in front of one bsg_cache bank
//
// Merges two link-to-cache adapters onto a single cache bank. Packets are
// arbitrated round-robin. The port that owns the request in the tag-lookup
// (tl) and tag-verify (tv) stages is tracked so that v_we and responses go
// back to the owning port only. All paths are combinational (0 cycles).
//
// Optional build macro: BSG_MANYCORE_CACHE_MERGE_BURST_LOCK_EN keeps up to
// burst_len_p consecutive grants on one port (icache word bursts).
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   cache_pkt_i / v_i       upstream packets and valids (port p at slice p)
//   yumi_o                  upstream packet accepted, per port
//   data_o / v_o / yumi_i   response data (both slices = cache_data_i), valid, accept
//   v_we_o                  tl->tv advance, routed to the tl owner
//   cache_pkt_o / cache_v_o / cache_yumi_i        packet to cache
//   cache_data_i / cache_v_i / cache_yumi_o       response from cache
//   cache_v_we_i            cache tl->tv advance
module bsg_manycore_cache_req_merge #(
  parameter int cache_pkt_width_p = 64,
  parameter int data_width_p      = 32,
  parameter int burst_len_p       = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [2*cache_pkt_width_p-1:0] cache_pkt_i,
  input  logic [1:0]                     v_i,
  output logic [1:0]                     yumi_o,
  output logic [2*data_width_p-1:0]      data_o,
  output logic [1:0]                     v_o,
  input  logic [1:0]                     yumi_i,
  output logic [1:0]                     v_we_o,
  output logic [cache_pkt_width_p-1:0]   cache_pkt_o,
  output logic                           cache_v_o,
  input  logic                           cache_yumi_i,
  input  logic [data_width_p-1:0]        cache_data_i,
  input  logic                           cache_v_i,
  output logic                           cache_yumi_o,
  input  logic                           cache_v_we_i
);

  logic rr_last_r;
  logic tl_v_r, tl_id_r;
  logic tv_v_r, tv_id_r;
  logic grant;
  logic accept;
  logic lock;

`ifdef BSG_MANYCORE_CACHE_MERGE_BURST_LOCK_EN
  localparam int cnt_w = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(burst_len_p - 1);

  logic [cnt_w-1:0] burst_cnt_r;
  // lock_v_r marks that rr_last_r is the port of a live burst (not just the
  // reset value), so the first grant after reset is plain round-robin.
  logic             lock_v_r;

  assign lock = lock_v_r & v_i[rr_last_r] & (burst_cnt_r < cnt_max);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      burst_cnt_r <= '0;
      lock_v_r    <= 1'b0;
    end else if (accept) begin
      if (lock_v_r && (grant == rr_last_r)) begin
        if (burst_cnt_r != cnt_max) burst_cnt_r <= burst_cnt_r + 1'b1;
      end else begin
        burst_cnt_r <= '0;
      end
      lock_v_r <= 1'b1;
    end else if (!v_i[rr_last_r]) begin
      // the burst owner dropped valid: the burst is over
      burst_cnt_r <= '0;
      lock_v_r    <= 1'b0;
    end
  end
`else
  assign lock = 1'b0;
`endif

  // Grant only moves on acceptance or a change in v_i, so cache_pkt_o is
  // stable while the cache stalls.
  always_comb begin
    grant = v_i[1];
    if (lock)               grant = rr_last_r;
    else if (v_i == 2'b11)  grant = ~rr_last_r;
  end

  assign cache_v_o   = reset_n_i & (|v_i);
  assign cache_pkt_o = grant ? cache_pkt_i[cache_pkt_width_p +: cache_pkt_width_p]
                             : cache_pkt_i[0 +: cache_pkt_width_p];
  assign accept      = cache_v_o & cache_yumi_i;
  assign yumi_o      = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign v_we_o       = (reset_n_i & cache_v_we_i) ? (tl_id_r ? 2'b10 : 2'b01) : 2'b00;
  assign v_o          = (reset_n_i & cache_v_i & tv_v_r) ? (tv_id_r ? 2'b10 : 2'b01) : 2'b00;
  assign cache_yumi_o = reset_n_i & cache_v_i & yumi_i[tv_id_r];
  assign data_o       = {2{cache_data_i}};

  // tl->tv shift reads the old tl_id_r; a same-cycle grant then reloads tl.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_last_r <= 1'b1;
      tl_v_r    <= 1'b0;
      tl_id_r   <= 1'b0;
      tv_v_r    <= 1'b0;
      tv_id_r   <= 1'b0;
    end else begin
      if (cache_v_we_i) begin
        tv_v_r  <= tl_v_r;
        tv_id_r <= tl_id_r;
      end else if (cache_yumi_o) begin
        tv_v_r  <= 1'b0;
      end

      if (accept) begin
        rr_last_r <= grant;
        tl_id_r   <= grant;
        tl_v_r    <= 1'b1;
      end else if (cache_v_we_i) begin
        tl_v_r    <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (cache_v_we_i && !tl_v_r) $error("cache_v_we_i with empty tl stage");
      if (cache_v_i && !tv_v_r)    $error("cache_v_i with empty tv stage");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_cache_req_merge.sv
// tb/tb_bsg_manycore_cache_req_merge.sv - scoreboard bench for bsg_manycore_cache_req_merge
module tb_bsg_manycore_cache_req_merge;

  localparam int PW = 16;
  localparam int DW = 32;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [2*PW-1:0] cache_pkt_i = '0;
  logic [1:0]      v_i = '0;
  logic [1:0]      yumi_o;
  logic [2*DW-1:0] data_o;
  logic [1:0]      v_o;
  logic [1:0]      yumi_i = '0;
  logic [1:0]      v_we_o;
  logic [PW-1:0]   cache_pkt_o;
  logic            cache_v_o;
  logic            cache_yumi_i = 1'b0;
  logic [DW-1:0]   cache_data_i = '0;
  logic            cache_v_i = 1'b0;
  logic            cache_yumi_o;
  logic            cache_v_we_i = 1'b0;

  always #5 clk = ~clk;

  bsg_manycore_cache_req_merge #(
    .cache_pkt_width_p(PW), .data_width_p(DW), .burst_len_p(BL)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cache_pkt_i(cache_pkt_i), .v_i(v_i),
    .yumi_o(yumi_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .v_we_o(v_we_o),
    .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_yumi_i(cache_yumi_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o),
    .cache_v_we_i(cache_v_we_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sources, response scoreboard, grant log
  logic [PW-1:0] src0[$], src1[$];
  logic [DW-1:0] exp0[$], exp1[$];
  int            grant_log[$];

  // cache pipeline and arbiter reference
  bit            s1_v, s1_p, s2_v, s2_p;
  logic [DW-1:0] s1_d, s2_d;
  bit            m_rr = 1'b1;
  int            m_cnt = 0;
  bit            m_lock_v = 1'b0;
  bit            cache_en = 1'b1;
  logic [1:0]    resp_rdy = 2'b11;
  logic [1:0]    last_v_we, last_v_o;

  function automatic logic [PW-1:0] mk(input int p, input int t, input int n);
    logic [3:0] tt;
    logic [7:0] nn;
    tt = 4'(t);
    nn = 8'(n);
    return {(p == 1) ? 4'hB : 4'hA, tt, nn};
  endfunction

  function automatic logic [DW-1:0] resp_of(input logic [PW-1:0] p);
    return {p ^ 16'hA5A5, p};
  endfunction

  // one clock: drive at posedge+1, check at negedge, advance reference
  task automatic step();
    bit consumed, we_go, acc, g;
    logic [1:0]    vin;
    logic [PW-1:0] p0, p1, pk;
    consumed = s2_v && resp_rdy[s2_p];
    we_go    = s1_v && (!s2_v || consumed);
    vin      = {src1.size() > 0, src0.size() > 0};
    p0       = (src0.size() > 0) ? src0[0] : '0;
    p1       = (src1.size() > 0) ? src1[0] : '0;
    if (vin == 2'b11) g = !m_rr;
    else              g = vin[1];
`ifdef BSG_MANYCORE_CACHE_MERGE_BURST_LOCK_EN
    if (m_lock_v && vin[m_rr] && m_cnt < BL - 1) g = m_rr;
`endif
    acc = cache_en && (!s1_v || we_go) && (vin != 2'b00);

    v_i          = vin;
    cache_pkt_i  = {p1, p0};
    cache_yumi_i = cache_en && (!s1_v || we_go);
    cache_v_we_i = we_go;
    cache_v_i    = s2_v;
    cache_data_i = s2_v ? s2_d : '0;
    yumi_i       = resp_rdy;
    #4;
    last_v_we = v_we_o;
    last_v_o  = v_o;
    check_eq("cache_v_o", cache_v_o, |vin);
    if (vin != 2'b00) check_eq("cache_pkt_o", cache_pkt_o, g ? p1 : p0);
    check_eq("yumi_o", yumi_o, acc ? (g ? 2'b10 : 2'b01) : 2'b00);
    check_eq("v_we_o", v_we_o, we_go ? (s1_p ? 2'b10 : 2'b01) : 2'b00);
    check_eq("v_o", v_o, s2_v ? (s2_p ? 2'b10 : 2'b01) : 2'b00);
    if (s2_v) check_eq("data_o", data_o, {2{s2_d}});
    check_eq("cache_yumi_o", cache_yumi_o, consumed);

    if (v_o[0] && yumi_i[0]) begin
      if (exp0.size() == 0) check_eq("resp0_unexpected", 1, 0);
      else check_eq("resp0_data", data_o[DW-1:0], exp0.pop_front());
    end
    if (v_o[1] && yumi_i[1]) begin
      if (exp1.size() == 0) check_eq("resp1_unexpected", 1, 0);
      else check_eq("resp1_data", data_o[2*DW-1:DW], exp1.pop_front());
    end

    if (we_go)         begin s2_v = 1'b1; s2_p = s1_p; s2_d = s1_d; end
    else if (consumed) s2_v = 1'b0;
    if (acc) begin
      pk = g ? src1.pop_front() : src0.pop_front();
      if (g) exp1.push_back(resp_of(pk));
      else   exp0.push_back(resp_of(pk));
      grant_log.push_back(int'(g));
      s1_v = 1'b1; s1_p = g; s1_d = resp_of(pk);
    end else if (we_go) begin
      s1_v = 1'b0;
    end
`ifdef BSG_MANYCORE_CACHE_MERGE_BURST_LOCK_EN
    if (acc) begin
      if (m_lock_v && g == m_rr) begin
        if (m_cnt < BL - 1) m_cnt++;
      end else begin
        m_cnt = 0;
      end
      m_lock_v = 1'b1;
    end else if (!vin[m_rr]) begin
      m_cnt = 0;
      m_lock_v = 1'b0;
    end
`endif
    if (acc) m_rr = g;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int max_cycles);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      busy = (src0.size() > 0) || (src1.size() > 0) || s1_v || s2_v;
      if (busy) begin
        step();
        n++;
      end
    end
    busy = (src0.size() > 0) || (src1.size() > 0) || s1_v || s2_v;
    check_eq("drain_timeout", busy, 0);
    check_eq("exp0_left", exp0.size(), 0);
    check_eq("exp1_left", exp1.size(), 0);
  endtask

  task automatic clear_model();
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete(); grant_log.delete();
    s1_v = 1'b0; s2_v = 1'b0; m_rr = 1'b1; m_cnt = 0; m_lock_v = 1'b0;
    cache_en = 1'b1; resp_rdy = 2'b11;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_cache_v_o"}, cache_v_o, 0);
    check_eq({tag, "_yumi_o"}, yumi_o, 0);
    check_eq({tag, "_v_o"}, v_o, 0);
    check_eq({tag, "_v_we_o"}, v_we_o, 0);
    check_eq({tag, "_cache_yumi_o"}, cache_yumi_o, 0);
  endtask

  int exp_pat[8];

  initial begin
`ifdef BSG_MANYCORE_CACHE_MERGE_BURST_LOCK_EN
    exp_pat = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_pat = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    #1 reset_n = 1'b0;
    v_i = 2'b11; cache_yumi_i = 1'b1; cache_v_i = 1'b1; cache_v_we_i = 1'b1; yumi_i = 2'b11;
    #2 check_outputs_zero("reset");
    v_i = '0; cache_yumi_i = 1'b0; cache_v_i = 1'b0; cache_v_we_i = 1'b0; yumi_i = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_model();

    // single port
    for (int i = 0; i < 8; i++) src0.push_back(mk(0, 1, i));
    run_idle(100);
    check_eq("t1_grants", grant_log.size(), 8);
    grant_log.delete();

    // contention
    for (int i = 0; i < 6; i++) begin
      src0.push_back(mk(0, 2, i));
      src1.push_back(mk(1, 2, i));
    end
    run_idle(100);
    check_eq("t2_grants", grant_log.size(), 12);
    grant_log.delete();

    // backpressure on packets, then on responses
    for (int i = 0; i < 3; i++) begin
      src0.push_back(mk(0, 3, i));
      src1.push_back(mk(1, 3, i));
    end
    cache_en = 1'b0;
    repeat (5) step();
    cache_en = 1'b1;
    repeat (2) step();
    resp_rdy = 2'b00;
    repeat (3) step();
    check_eq("t3_held_v_o", last_v_o != 2'b00, 1);
    resp_rdy = 2'b11;
    run_idle(100);
    grant_log.delete();

    // coincident v_we and new grant
    src1.push_back(mk(1, 4, 0));
    step();
    src0.push_back(mk(0, 4, 1));
    step();
    check_eq("t4_coincident_v_we", last_v_we, 2'b10);
    step();
    check_eq("t4_tv_owner", last_v_o, 2'b10);
    check_eq("t4_tl_owner", last_v_we, 2'b01);
    run_idle(50);
    grant_log.delete();

    // asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      src0.push_back(mk(0, 5, i));
      src1.push_back(mk(1, 5, i));
    end
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    clear_model();
    v_i = '0; cache_yumi_i = 1'b0; cache_v_i = 1'b0; cache_v_we_i = 1'b0; yumi_i = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // grant pattern with both ports continuously valid
    for (int i = 0; i < 8; i++) begin
      src0.push_back(mk(0, 6, i));
      src1.push_back(mk(1, 6, i));
    end
    run_idle(200);
    if (grant_log.size() < 8) check_eq("t6_grant_count", grant_log.size(), 8);
    else for (int i = 0; i < 8; i++) check_eq($sformatf("t6_grant_%0d", i), grant_log[i], exp_pat[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
